// File: rtl/instr_loader_pkg.sv
// rtl/instr_loader_pkg.sv - shared types and constants for the instruction loader
package instr_loader_pkg;

    typedef enum logic [2:0] {
        S_CNT0,
        S_CNT1,
        S_DATA,
        S_CSUM,
        S_DONE,
        S_ERR
    } state_t;

    localparam int BYTES_PER_WORD = 4;
    localparam int CNT_WIDTH      = 16;

    // Packed as {rx_ready, cpu_rst, done, error} for the state being entered.
    function automatic logic [3:0] status_of(input state_t s);
        return {(s != S_DONE) && (s != S_ERR), s != S_DONE, s == S_DONE, s == S_ERR};
    endfunction

endpackage

// File: rtl/byte_packer.sv
// rtl/byte_packer.sv - assembles little-endian 32-bit words from byte beats
module byte_packer
    import instr_loader_pkg::*;
(
    input  logic        clk,
    input  logic        clear,
    input  logic        beat_valid,
    input  logic [7:0]  beat_data,
    output logic        word_done,
    output logic [31:0] word
);

    logic [1:0]  byte_idx;
    logic [23:0] low_bytes;

    // The fourth beat is used directly so the word is ready on the same edge.
    assign word_done = beat_valid && (byte_idx == 2'(BYTES_PER_WORD - 1));
    assign word      = {beat_data, low_bytes};

    always_ff @(posedge clk) begin
        if (clear) begin
            byte_idx  <= 2'd0;
            low_bytes <= 24'd0;
        end else if (beat_valid) begin
            byte_idx  <= byte_idx + 2'd1;
            low_bytes <= {beat_data, low_bytes[23:8]};
        end
    end

endmodule

// File: rtl/instr_loader.sv
// rtl/instr_loader.sv - framed byte-stream boot loader for instruction memory
module instr_loader
    import instr_loader_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_SIZE   = 512
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [7:0]            rx_data,
    input  logic                  rx_valid,
    output logic                  rx_ready,
    input  logic                  start,
    output logic                  imem_we,
    output logic [ADDR_WIDTH-1:0] imem_waddr,
    output logic [DATA_WIDTH-1:0] imem_wdata,
    output logic                  cpu_rst,
    output logic                  done,
    output logic                  error
);

    localparam int WIDX_W = $clog2(MEM_SIZE) + 1;

    state_t                 state;
    logic [CNT_WIDTH-1:0]   cnt;
    logic [7:0]             csum;
    logic [WIDX_W-1:0]      widx;
    logic                   fire;
    logic                   beat;
    logic                   clear;
    logic                   word_done;
    logic [31:0]            word;
    logic [CNT_WIDTH-1:0]   cnt_full;
    logic                   last_word;

    assign fire      = rx_valid && rx_ready;
    assign beat      = fire && (state == S_DATA);
    assign clear     = reset || (start && ((state == S_DONE) || (state == S_ERR)));
    assign cnt_full  = {rx_data, cnt[7:0]};
    assign last_word = (CNT_WIDTH'(widx) + CNT_WIDTH'(1)) == cnt;

    byte_packer u_packer (
        .clk        (clk),
        .clear      (clear),
        .beat_valid (beat),
        .beat_data  (rx_data),
        .word_done  (word_done),
        .word       (word)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state                           <= S_CNT0;
            {rx_ready, cpu_rst, done, error} <= status_of(S_CNT0);
            imem_we                         <= 1'b0;
            imem_waddr                      <= '0;
            imem_wdata                      <= '0;
            cnt                             <= '0;
            csum                            <= 8'd0;
            widx                            <= '0;
        end else begin
            imem_we <= 1'b0;
            case (state)
                S_CNT0: if (fire) begin
                    cnt[7:0] <= rx_data;
                    csum     <= csum ^ rx_data;
                    state    <= S_CNT1;
                end
                S_CNT1: if (fire) begin
                    cnt  <= cnt_full;
                    csum <= csum ^ rx_data;
                    if (cnt_full > CNT_WIDTH'(MEM_SIZE)) begin
                        state                           <= S_ERR;
                        {rx_ready, cpu_rst, done, error} <= status_of(S_ERR);
                    end else if (cnt_full == '0) begin
                        state <= S_CSUM;
                    end else begin
                        state <= S_DATA;
                    end
                end
                S_DATA: if (fire) begin
                    csum <= csum ^ rx_data;
                    if (word_done) begin
                        imem_we    <= 1'b1;
                        imem_waddr <= ADDR_WIDTH'({widx, 2'b00});
                        imem_wdata <= DATA_WIDTH'(word);
                        widx       <= widx + 1'b1;
                        if (last_word) state <= S_CSUM;
                    end
                end
                S_CSUM: if (fire) begin
                    if (rx_data == csum) begin
                        state                           <= S_DONE;
                        {rx_ready, cpu_rst, done, error} <= status_of(S_DONE);
                    end else begin
                        state                           <= S_ERR;
                        {rx_ready, cpu_rst, done, error} <= status_of(S_ERR);
                    end
                end
                S_DONE, S_ERR: if (start) begin
                    state                           <= S_CNT0;
                    {rx_ready, cpu_rst, done, error} <= status_of(S_CNT0);
                    csum                            <= 8'd0;
                    widx                            <= '0;
                    cnt                             <= '0;
                end
                default: begin
                    state                           <= S_CNT0;
                    {rx_ready, cpu_rst, done, error} <= status_of(S_CNT0);
                end
            endcase
        end
    end

endmodule

// File: tb/tb_instr_loader.sv
// tb/tb_instr_loader.sv - self-checking bench for instr_loader
module tb_instr_loader;

    typedef logic [7:0]  byte_q_t[$];
    typedef logic [63:0] wr_q_t[$];

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [7:0]  rx_data = 8'd0;
    logic        rx_valid = 1'b0;
    logic        rx_ready;
    logic        start = 1'b0;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic        cpu_rst;
    logic        done;
    logic        error;

    int n_checks = 0;
    int n_pass   = 0;
    int pulse_bad = 0;
    int late_wr   = 0;
    logic  prev_we = 1'b0;
    wr_q_t wr_q;

    instr_loader dut (
        .clk        (clk),
        .reset      (reset),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .rx_ready   (rx_ready),
        .start      (start),
        .imem_we    (imem_we),
        .imem_waddr (imem_waddr),
        .imem_wdata (imem_wdata),
        .cpu_rst    (cpu_rst),
        .done       (done),
        .error      (error)
    );

    always #5 clk = ~clk;

    // Write monitor, sampled away from the rising edge.
    always @(negedge clk) begin
        if (imem_we) begin
            wr_q.push_back({imem_waddr, imem_wdata});
            if (prev_we) pulse_bad++;
            if (!cpu_rst) late_wr++;
        end
        prev_we = imem_we;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference: parse the frame by its rules and list the expected writes and outcome.
    task automatic model(input byte_q_t f, output wr_q_t exp, output bit exp_done);
        int n;
        logic [7:0] x;
        exp = {};
        n = int'({f[1], f[0]});
        exp_done = 1'b0;
        if (n > 512) return;
        x = f[0] ^ f[1];
        for (int k = 0; k < n; k++) begin
            logic [31:0] w;
            w = {f[2+4*k+3], f[2+4*k+2], f[2+4*k+1], f[2+4*k]};
            for (int b = 0; b < 4; b++) x = x ^ f[2+4*k+b];
            exp.push_back({32'(k*4), w});
        end
        exp_done = (f[2+4*n] == x);
    endtask

    function automatic byte_q_t make_frame(input int n, input bit bad);
        byte_q_t f;
        logic [7:0] x;
        logic [15:0] n16;
        n16 = 16'(n);
        f.push_back(n16[7:0]);
        f.push_back(n16[15:8]);
        for (int i = 0; i < 4*n; i++) f.push_back(8'($urandom));
        x = 8'd0;
        foreach (f[i]) x = x ^ f[i];
        f.push_back(bad ? (x ^ 8'($urandom_range(1, 255))) : x);
        return f;
    endfunction

    // gap_mode: 0 none, 1 every other cycle, 2 random
    task automatic send_bytes(input byte_q_t f, input int gap_mode, output int accepted);
        bit ph;
        ph = 1'b0;
        accepted = 0;
        foreach (f[i]) begin
            bit sent;
            int guard;
            sent = 1'b0;
            guard = 0;
            while (!sent && guard < 50) begin
                @(negedge clk);
                ph = ~ph;
                if ((gap_mode == 1 && ph) || (gap_mode == 2 && $urandom_range(0, 1) == 1)) begin
                    rx_valid = 1'b0;
                end else begin
                    rx_valid = 1'b1;
                    rx_data  = f[i];
                    if (rx_ready) sent = 1'b1;
                end
                guard++;
            end
            if (!sent) break;
            accepted++;
        end
        @(negedge clk);
        rx_valid = 1'b0;
    endtask

    task automatic run_frame(input string tag, input byte_q_t f, input int gap_mode);
        wr_q_t exp;
        bit exp_done;
        int acc;
        model(f, exp, exp_done);
        wr_q.delete();
        send_bytes(f, gap_mode, acc);
        check({tag, ".accepted"}, 64'(acc), 64'(f.size()));
        check({tag, ".nwrites"}, 64'(wr_q.size()), 64'(exp.size()));
        for (int i = 0; i < exp.size() && i < wr_q.size(); i++)
            check($sformatf("%s.wr%0d", tag, i), wr_q[i], exp[i]);
        check({tag, ".done"}, 64'(done), 64'(exp_done));
        check({tag, ".error"}, 64'(error), 64'(!exp_done));
        check({tag, ".cpu_rst"}, 64'(cpu_rst), 64'(!exp_done));
        check({tag, ".rx_ready"}, 64'(rx_ready), 64'd0);
    endtask

    task automatic do_start(input string tag);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check({tag, ".start_error"}, 64'(error), 64'd0);
        check({tag, ".start_done"}, 64'(done), 64'd0);
        check({tag, ".start_ready"}, 64'(rx_ready), 64'd1);
        check({tag, ".start_cpu_rst"}, 64'(cpu_rst), 64'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, ".rx_ready"}, 64'(rx_ready), 64'd1);
        check({tag, ".cpu_rst"}, 64'(cpu_rst), 64'd1);
        check({tag, ".done"}, 64'(done), 64'd0);
        check({tag, ".error"}, 64'(error), 64'd0);
        check({tag, ".we"}, 64'(imem_we), 64'd0);
        check({tag, ".waddr"}, 64'(imem_waddr), 64'd0);
        check({tag, ".wdata"}, 64'(imem_wdata), 64'd0);
    endtask

    initial begin
        byte_q_t normal, bad, f;
        int acc;
        normal = '{8'h02, 8'h00, 8'h93, 8'h00, 8'h50, 8'h00, 8'h13, 8'h01, 8'hA0, 8'h00, 8'h73};
        bad = normal;
        bad[10] = 8'h74;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        check_reset_values("reset");

        run_frame("normal", normal, 0);
        check("normal.wr0_const", wr_q.size() > 0 ? wr_q[0] : 64'hx, {32'h0, 32'h00500093});
        check("normal.wr1_const", wr_q.size() > 1 ? wr_q[1] : 64'hx, {32'h4, 32'h00A00113});

        do_start("pre_bad");
        run_frame("bad_csum", bad, 0);

        do_start("restart");
        run_frame("gapped", normal, 1);

        do_start("pre_over");
        wr_q.delete();
        f = '{8'h01, 8'h02};
        send_bytes(f, 0, acc);
        check("over.error", 64'(error), 64'd1);
        check("over.cpu_rst", 64'(cpu_rst), 64'd1);
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1;
            rx_data  = 8'h55;
            check($sformatf("over.ready%0d", i), 64'(rx_ready), 64'd0);
            @(negedge clk);
        end
        rx_valid = 1'b0;
        check("over.still_error", 64'(error), 64'd1);
        check("over.nwrites", 64'(wr_q.size()), 64'd0);

        do_start("pre_empty");
        f = '{8'h00, 8'h00, 8'h00};
        run_frame("empty", f, 0);

        do_start("pre_midword");
        wr_q.delete();
        f = '{8'h02, 8'h00, 8'h93, 8'h00};
        send_bytes(f, 0, acc);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check("midword.nwrites", 64'(wr_q.size()), 64'd0);
        check_reset_values("midword_reset");
        run_frame("after_reset", normal, 0);

        for (int t = 0; t < 8; t++) begin
            int n;
            do_start($sformatf("rnd%0d", t));
            if (t == 5) begin
                n = $urandom_range(513, 900);
                f = '{8'(n), 8'(n >> 8)};
            end else begin
                n = (t == 2) ? 512 : $urandom_range(0, 6);
                f = make_frame(n, $urandom_range(0, 3) == 0);
            end
            run_frame($sformatf("rnd%0d", t), f, 2);
        end

        check("one_cycle_pulses", 64'(pulse_bad), 64'd0);
        check("no_write_after_release", 64'(late_wr), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
